// File: rtl/bwn_pkg.sv
// Shared definitions for the BWN accelerator datapath stages (ReLU, pooling).
// Holds default word-format constants and the signed-max helper used by the compare logic.
// Pure declarations: no timing, no flow control.
package bwn_pkg;

  // Default data word length and fractional bits of the fixed-point format.
  localparam int DEF_D_WL = 24;
  localparam int DEF_FL   = 16;

  // Widest word smax() handles. Callers sign-extend their words into this width.
  localparam int SMAX_WL  = 64;

  // Signed maximum. On a tie the first operand (the older value) is returned.
  function automatic logic [SMAX_WL-1:0] smax(input logic signed [SMAX_WL-1:0] a,
                                               input logic signed [SMAX_WL-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding horizontal maxima of an even row until the odd row below consumes them.
// Latency: write takes effect on the next CLK edge; read is combinational.
// No flow control: writes are accepted whenever wr_en_i is high.
module pool_line_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  // No reset: every entry is written by an even row before the odd row reads it.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single write port.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling over a raster-ordered single-channel frame.
// Latency: out_valid/out_data register on the edge that samples the completing (odd row, odd col) beat.
// No backpressure: one output per 4 accepted inputs, consumer must take every out_valid pulse.
module maxpool2x2_stream
  import bwn_pkg::*;
#(
  parameter int D_WL  = bwn_pkg::DEF_D_WL,
  parameter int FL    = bwn_pkg::DEF_FL,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [D_WL-1:0] in_data,
  output logic            out_valid,
  output logic [D_WL-1:0] out_data,
  output logic            frame_done
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Reject geometries the 2x2 window cannot tile, and formats the shared helper cannot hold.
  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("maxpool2x2_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("maxpool2x2_stream: IMG_H must be even and >= 2");
  end
  if (D_WL < 1 || D_WL > SMAX_WL) begin : g_bad_d_wl
    $error("maxpool2x2_stream: D_WL out of range for smax");
  end
  if (FL < 0 || FL >= D_WL) begin : g_bad_fl
    $error("maxpool2x2_stream: FL must lie within the data word");
  end

  // Signed max at D_WL bits via the shared helper; tie keeps the first (older) operand.
  function automatic logic [D_WL-1:0] pmax(input logic [D_WL-1:0] older,
                                           input logic [D_WL-1:0] newer);
    logic [SMAX_WL-1:0] wide;
    wide = smax(SMAX_WL'(signed'(older)), SMAX_WL'(signed'(newer)));
    return wide[D_WL-1:0];
  endfunction

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [D_WL-1:0]  h_q, h_d;
  logic             out_valid_q, out_valid_d;
  logic [D_WL-1:0]  out_data_q, out_data_d;
  logic             frame_done_q, frame_done_d;

  logic             lb_we;
  logic [LB_AW-1:0] lb_addr;
  logic [D_WL-1:0]  lb_rd;
  logic [D_WL-1:0]  hmax;

  // Even rows write a column pair's maximum; the odd row below reads the same slot.
  assign lb_addr = LB_AW'(col_q >> 1);
  assign hmax    = pmax(h_q, in_data);

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (D_WL),
    .AW    (LB_AW)
  ) u_line_buf (
    .CLK       (CLK),
    .wr_en_i   (lb_we),
    .wr_addr_i (lb_addr),
    .wr_data_i (hmax),
    .rd_addr_i (lb_addr),
    .rd_data_o (lb_rd)
  );

  // Next-state: raster counters, horizontal pair register, line-buffer write and output strobes.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    if (clr) begin
      // Frame restart wins over a beat in the same cycle; that beat is dropped.
      col_d = '0;
      row_d = '0;
      h_d   = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end

      if (!col_q[0]) begin
        // Left pixel of the pair: hold it for the right pixel.
        h_d = in_data;
      end else if (!row_q[0]) begin
        // Top row of the window: park the pair maximum for the row below.
        lb_we = 1'b1;
      end else begin
        // Bottom-right pixel completes the window; the top-row maximum is the older value.
        out_valid_d = 1'b1;
        out_data_d  = pmax(lb_rd, hmax);
      end
    end
  end

  // State and output registers; asynchronous reset discards any partial frame.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule
